// File: rtl/round_ctrl_if.sv
// Bus bundle between the round controller and the game/cursor stages.
// Directions are named from the controller's side (i_ into it, o_ out of it).
interface round_ctrl_if;
    logic        i_frame_clk;
    logic        i_start;
    logic        i_shot;
    logic        i_bird_shot;
    logic [2:0]  o_state;
    logic        o_no_shots_left;
    logic [1:0]  o_shots_left;
    logic [3:0]  o_duck_num;
    logic [3:0]  o_hits;
    logic [9:0]  o_hit_flags;
    logic [6:0]  o_round_num;
    logic [15:0] o_score;
    logic        o_new_duck;

    modport master (
        output i_frame_clk, i_start, i_shot, i_bird_shot,
        input  o_state, o_no_shots_left, o_shots_left, o_duck_num, o_hits,
               o_hit_flags, o_round_num, o_score, o_new_duck
    );

    modport slave (
        input  i_frame_clk, i_start, i_shot, i_bird_shot,
        output o_state, o_no_shots_left, o_shots_left, o_duck_num, o_hits,
               o_hit_flags, o_round_num, o_score, o_new_duck
    );
endinterface

// File: rtl/round_ctrl.sv
// Duck-hunt round sequencer: frame-timed game FSM with per-duck shot budget,
// hit bookkeeping, saturating score and round progression.
//
// state      | meaning
// TITLE      | idle after reset, waits for start press
// START      | round intro, START_FRAMES frames
// PLAY       | duck flying, shots accepted
// HIT        | duck hit animation, HIT_FRAMES frames
// MISS       | duck escaped animation, MISS_FRAMES frames
// ROUND_END  | single-cycle pass/fail decision
// GAME_OVER  | final score shown, waits for start press
module round_ctrl #(
    parameter int SHOTS_PER_DUCK  = 3,
    parameter int DUCKS_PER_ROUND = 10,
    parameter int PASS_HITS       = 6,
    parameter int POINTS          = 500,
    parameter int START_FRAMES    = 120,
    parameter int FLY_FRAMES      = 300,
    parameter int HIT_FRAMES      = 90,
    parameter int MISS_FRAMES     = 90
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    round_ctrl_if.slave io_bus
);

    typedef enum logic [2:0] {
        S_TITLE     = 3'b000,
        S_START     = 3'b001,
        S_PLAY      = 3'b010,
        S_HIT       = 3'b011,
        S_MISS      = 3'b100,
        S_ROUND_END = 3'b101,
        S_GAME_OVER = 3'b110
    } state_t;

    localparam logic [8:0]  START_T    = 9'(START_FRAMES);
    localparam logic [8:0]  FLY_T      = 9'(FLY_FRAMES);
    localparam logic [8:0]  HIT_T      = 9'(HIT_FRAMES);
    localparam logic [8:0]  MISS_T     = 9'(MISS_FRAMES);
    localparam logic [1:0]  SHOTS_INIT = 2'(SHOTS_PER_DUCK);
    localparam logic [3:0]  LAST_DUCK  = 4'(DUCKS_PER_ROUND - 1);
    localparam logic [3:0]  PASS_H     = 4'(PASS_HITS);
    localparam logic [16:0] PTS_W      = 17'(POINTS);
    localparam logic [6:0]  ROUND_MAX  = 7'd99;

    logic        r_frame_sync1, r_frame_sync2, r_frame_prev;
    logic        r_start_prev, r_shot_prev, r_edge_armed;
    state_t      r_state;
    logic [8:0]  r_timer;
    logic [1:0]  r_shots_left;
    logic [3:0]  r_duck_num;
    logic [3:0]  r_hits;
    logic [9:0]  r_hit_flags;
    logic [6:0]  r_round_num;
    logic [15:0] r_score;
    logic        r_new_duck;

    logic        w_frame_tick, w_start_edge, w_shot_edge;
    logic [16:0] w_score_sum;
    logic        w_timer_run, w_dwell_done;
    state_t      w_state_nxt;
    logic [8:0]  w_timer_nxt;
    logic [1:0]  w_shots_nxt;
    logic [3:0]  w_duck_nxt;
    logic [3:0]  w_hits_nxt;
    logic [9:0]  w_flags_nxt;
    logic [6:0]  w_round_nxt;
    logic [15:0] w_score_nxt;
    logic        w_new_duck_nxt;

    // r_edge_armed blocks edges on the first cycle after reset so that a button
    // held through reset release is not seen as a fresh press.
    assign w_frame_tick = r_frame_sync2 & ~r_frame_prev;
    assign w_start_edge = io_bus.i_start & ~r_start_prev & r_edge_armed;
    assign w_shot_edge  = io_bus.i_shot  & ~r_shot_prev  & r_edge_armed;
    assign w_score_sum  = {1'b0, r_score} + PTS_W;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_sync1 <= 1'b0;
            r_frame_sync2 <= 1'b0;
            r_frame_prev  <= 1'b0;
            r_start_prev  <= 1'b0;
            r_shot_prev   <= 1'b0;
            r_edge_armed  <= 1'b0;
        end else begin
            r_frame_sync1 <= io_bus.i_frame_clk;
            r_frame_sync2 <= r_frame_sync1;
            r_frame_prev  <= r_frame_sync2;
            r_start_prev  <= io_bus.i_start;
            r_shot_prev   <= io_bus.i_shot;
            r_edge_armed  <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_TITLE;
            r_timer      <= '0;
            r_shots_left <= '0;
            r_duck_num   <= '0;
            r_hits       <= '0;
            r_hit_flags  <= '0;
            r_round_num  <= 7'd1;
            r_score      <= '0;
            r_new_duck   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_shots_left <= w_shots_nxt;
            r_duck_num   <= w_duck_nxt;
            r_hits       <= w_hits_nxt;
            r_hit_flags  <= w_flags_nxt;
            r_round_num  <= w_round_nxt;
            r_score      <= w_score_nxt;
            r_new_duck   <= w_new_duck_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shots_nxt  = r_shots_left;
        w_duck_nxt   = r_duck_num;
        w_hits_nxt   = r_hits;
        w_flags_nxt  = r_hit_flags;
        w_round_nxt  = r_round_num;
        w_score_nxt  = r_score;
        w_timer_run  = 1'b0;
        w_dwell_done = 1'b0;

        case (r_state)
            S_TITLE, S_GAME_OVER: begin
                if (w_start_edge) begin
                    w_state_nxt = S_START;
                    w_score_nxt = '0;
                    w_round_nxt = 7'd1;
                    w_duck_nxt  = '0;
                    w_hits_nxt  = '0;
                    w_flags_nxt = '0;
                end
            end
            S_START: begin
                w_timer_run = 1'b1;
                if (r_timer == START_T) begin
                    w_state_nxt = S_PLAY;
                    w_shots_nxt = SHOTS_INIT;
                end
            end
            S_PLAY: begin
                w_timer_run = 1'b1;
                if (w_shot_edge && (r_shots_left != 2'd0))
                    w_shots_nxt = r_shots_left - 2'd1;
                // The empty-gun miss waits for a frame tick so a hit from the
                // last shot still has one frame to arrive from the cursor stage.
                if (io_bus.i_bird_shot) begin
                    w_state_nxt = S_HIT;
                    w_hits_nxt  = r_hits + 4'd1;
                    w_flags_nxt = r_hit_flags | (10'd1 << r_duck_num);
                    w_score_nxt = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
                end else if ((r_shots_left == 2'd0) && w_frame_tick) begin
                    w_state_nxt = S_MISS;
                end else if (r_timer == FLY_T) begin
                    w_state_nxt = S_MISS;
                end
            end
            S_HIT, S_MISS: begin
                w_timer_run  = 1'b1;
                w_dwell_done = (r_state == S_HIT) ? (r_timer == HIT_T) : (r_timer == MISS_T);
                if (w_dwell_done) begin
                    if (r_duck_num == LAST_DUCK) begin
                        w_state_nxt = S_ROUND_END;
                    end else begin
                        w_state_nxt = S_PLAY;
                        w_duck_nxt  = r_duck_num + 4'd1;
                        w_shots_nxt = SHOTS_INIT;
                    end
                end
            end
            S_ROUND_END: begin
                if (r_hits >= PASS_H) begin
                    w_state_nxt = S_START;
                    w_round_nxt = (r_round_num >= ROUND_MAX) ? ROUND_MAX : r_round_num + 7'd1;
                    w_duck_nxt  = '0;
                    w_hits_nxt  = '0;
                    w_flags_nxt = '0;
                end else begin
                    w_state_nxt = S_GAME_OVER;
                end
            end
            default: w_state_nxt = S_TITLE;
        endcase

        if (w_state_nxt != r_state)
            w_timer_nxt = '0;
        else if (w_timer_run && w_frame_tick)
            w_timer_nxt = r_timer + 9'd1;
        else
            w_timer_nxt = r_timer;

        w_new_duck_nxt = (w_state_nxt == S_PLAY) && (r_state != S_PLAY);
    end

    assign io_bus.o_state         = r_state;
    assign io_bus.o_shots_left    = r_shots_left;
    assign io_bus.o_no_shots_left = (r_shots_left == 2'd0);
    assign io_bus.o_duck_num      = r_duck_num;
    assign io_bus.o_hits          = r_hits;
    assign io_bus.o_hit_flags     = r_hit_flags;
    assign io_bus.o_round_num     = r_round_num;
    assign io_bus.o_score         = r_score;
    assign io_bus.o_new_duck      = r_new_duck;

endmodule

// File: doc/round_ctrl.md
ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 Params: SHOTS_PER_DUCK, default 3, shots per duck; DUCKS_PER_ROUND, default 10, ducks per round; PASS_HITS, default 6, hits needed to advance; POINTS, default 500, score per hit; START_FRAMES, default 120; FLY_FRAMES, default 300; HIT_FRAMES, default 90; MISS_FRAMES, default 90.
REQ-002 Clk  in  1  system clock, 50 MHz.
REQ-003 Reset_n  in  1  asynchronous active-low reset.
REQ-004 frame_clk  in  1  ~60 Hz frame clock, async level.
REQ-005 start  in  1  start button, level.
REQ-006 shot  in  1  trigger, level.
REQ-007 bird_shot  in  1  hit pulse from cursor stage.
REQ-008 state  out  3  game state code, consumed by cursor stage.
REQ-009 no_shots_left  out  1  high when shots_left == 0.
REQ-010 shots_left  out  2  remaining shots for current duck.
REQ-011 duck_num  out  4  current duck index, 0..DUCKS_PER_ROUND-1.
REQ-012 hits  out  4  hits this round.
REQ-013 hit_flags  out  10  per-duck hit record, bit i = duck i hit.
REQ-014 round_num  out  7  round counter, starts 1.
REQ-015 score  out  16  accumulated score.
REQ-016 new_duck  out  1  one-cycle pulse on every entry to PLAY.

Function
REQ-017 frame_tick SHALL be a one-Clk pulse on each frame_clk rising edge (two-flop synchroniser plus edge detect).
REQ-018 shot_edge and start_edge SHALL be one-Clk pulses on rising edges of shot and start (registered previous value).
REQ-019 States SHALL be TITLE=000, START=001, PLAY=010, HIT=011, MISS=100, ROUND_END=101, GAME_OVER=110; 111 unreachable, SHALL recover to TITLE next cycle.
REQ-020 A 9-bit frame timer SHALL clear on every state change and increment on frame_tick in START, PLAY, HIT, MISS.
REQ-021 TITLE: start_edge -> START; clears score, round_num=1, duck_num=0, hits=0, hit_flags=0.
REQ-022 START: timer == START_FRAMES -> PLAY; shots_left=SHOTS_PER_DUCK on entry to PLAY.
REQ-023 PLAY: shot_edge with shots_left>0 SHALL decrement shots_left; shot_edge at 0 SHALL be ignored.
REQ-024 PLAY: bird_shot -> HIT same cycle; hits+1, hit_flags[duck_num]=1, score += POINTS saturating at 16'hFFFF.
REQ-025 PLAY: bird_shot and shot_edge in same cycle -> both take effect (decrement and hit).
REQ-026 PLAY: shots_left==0 and frame_tick and no bird_shot -> MISS (one-frame grace for cursor stage hit detection).
REQ-027 PLAY: timer == FLY_FRAMES and no bird_shot -> MISS regardless of shots_left.
REQ-028 bird_shot outside PLAY SHALL be ignored; one duck SHALL score at most once.
REQ-029 HIT: timer == HIT_FRAMES; MISS: timer == MISS_FRAMES -> if duck_num == DUCKS_PER_ROUND-1 then ROUND_END else duck_num+1 and PLAY.
REQ-030 ROUND_END (one cycle): hits >= PASS_HITS -> START with round_num+1 (saturate 99), duck_num=0, hits=0, hit_flags=0; else GAME_OVER.
REQ-031 GAME_OVER: outputs held; start_edge -> START with same clears as REQ-021.
REQ-032 new_duck SHALL pulse exactly in the cycle state becomes PLAY.
REQ-033 All outputs SHALL be registered except no_shots_left (decoded from shots_left).

Reset
REQ-034 Reset_n low SHALL asynchronously force state=TITLE, shots_left=0, duck_num=0, hits=0, hit_flags=0, round_num=1, score=0, new_duck=0, timer=0, edge-detect flops=0.
REQ-035 Reset mid-PLAY SHALL abandon the round; no score retained; release needs a fresh start_edge.
REQ-036 start, shot held high through reset release SHALL NOT generate an edge.

Verification
REQ-037 Reset, start pulse, 120 frame ticks -> state 010, shots_left=3, new_duck one cycle.
REQ-038 PLAY, three shot edges no hit, one more frame_tick -> shots_left=0, no_shots_left=1, state 100; fourth shot edge ignored.
REQ-039 PLAY, shot_edge and bird_shot same cycle -> shots_left=2, hits=1, score=500, hit_flags[0]=1, state 011.
REQ-040 Ten ducks, 6 hits -> ROUND_END then START, round_num=2, hits=0; repeat with 5 hits -> GAME_OVER, score held.
REQ-041 No shots, 300 frame ticks -> MISS; bird_shot pulse during MISS -> no score change.
REQ-042 Reset_n low mid-HIT with score=1500 -> immediately state 000, score=0; start held through release -> stays TITLE.
